// File: rtl/bp_be_dep_status_tracker_pkg.sv
// Shared types for the backend dependency-status producer/consumer pair.
// The dep_status struct width is exported so both sides size their ports identically.
package bp_be_dep_status_tracker_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_inv_cfg
    } bp_params_e;

    localparam int reg_addr_width_p = 5;

    typedef struct packed {
        logic                        v;
        logic                        long_v;
        logic                        mem_v;
        logic                        serial_v;
        logic                        mem_iwb_v;
        logic                        mul_iwb_v;
        logic                        fp_iwb_v;
        logic                        aux_fwb_v;
        logic                        mem_fwb_v;
        logic                        fp_fwb_v;
        logic [reg_addr_width_p-1:0] rd_addr;
    } bp_be_dep_status_s;

    localparam int dep_status_width_gp = $bits(bp_be_dep_status_s);

endpackage

// File: rtl/bp_be_credit_counter.sv
// Up/down saturating credit counter with full/empty flags and a sticky
// over/underflow error; also used by the fence logic.
module bp_be_credit_counter #(
    parameter int credits_p = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic take_i,
    input  logic return_i,
    output logic full_o,
    output logic empty_o,
    output logic err_o
);

    localparam int cnt_width_lp = $clog2(credits_p+1);
    localparam logic [cnt_width_lp-1:0] max_lp = cnt_width_lp'(credits_p);

    logic [cnt_width_lp-1:0] count_r;
    logic                    err_r;

    assign full_o  = (count_r == max_lp);
    assign empty_o = (count_r == '0);
    assign err_o   = err_r;

    // A simultaneous take and return nets to zero, so it can never overflow.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r <= '0;
            err_r   <= 1'b0;
        end else if (take_i && !return_i) begin
            if (full_o) err_r   <= 1'b1;
            else        count_r <= count_r + 1'b1;
        end else if (return_i && !take_i) begin
            if (empty_o) err_r   <= 1'b1;
            else         count_r <= count_r - 1'b1;
        end
    end

endmodule

// File: rtl/bp_be_dep_status_tracker.sv
// Producer side of the dependency-status interface: five never-stalling slots
// of dispatched-instruction attributes, memory credits and long-latency busy.
module bp_be_dep_status_tracker
    import bp_be_dep_status_tracker_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_inv_cfg,
    parameter int stages_p  = 5,
    parameter int credits_p = 8,
    localparam int dep_status_width_lp = dep_status_width_gp
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    dispatch_v_i,
    input  logic [dep_status_width_lp-1:0]          dispatch_info_i,
    input  logic [stages_p-1:0]                     poison_i,
    input  logic                                    credit_take_i,
    input  logic                                    credit_return_i,
    input  logic                                    long_done_i,
    output logic [stages_p*dep_status_width_lp-1:0] dep_status_o,
    output logic                                    long_busy_o,
    output logic                                    credits_full_o,
    output logic                                    credits_empty_o,
    output logic                                    credit_err_o
);

    localparam bp_params_e unused_cfg_lp = bp_params_p;

    bp_be_dep_status_s                dispatch_info;
    bp_be_dep_status_s                slot0_n;
    bp_be_dep_status_s [stages_p-1:0] slot_r;
    logic                             long_busy_r;
    logic                             unused_poison;

    // The last slot is discarded every cycle, so its poison bit is moot.
    assign unused_poison = poison_i[stages_p-1];
    assign dispatch_info = bp_be_dep_status_s'(dispatch_info_i);

    always_comb begin
        slot0_n   = dispatch_info;
        slot0_n.v = 1'b1;
        if (!dispatch_v_i) slot0_n = '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slot_r <= '0;
        end else begin
            slot_r[0] <= slot0_n;
            for (int i = 1; i < stages_p; i++)
                slot_r[i] <= poison_i[i-1] ? '0 : slot_r[i-1];
        end
    end

    // A new long op wins over a same-cycle done; poison never clears busy.
    always_ff @(posedge clk_i) begin
        if (reset_i)                               long_busy_r <= 1'b0;
        else if (dispatch_v_i && dispatch_info.long_v) long_busy_r <= 1'b1;
        else if (long_done_i)                      long_busy_r <= 1'b0;
    end

    bp_be_credit_counter #(
        .credits_p(credits_p)
    ) u_credit (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .take_i  (credit_take_i),
        .return_i(credit_return_i),
        .full_o  (credits_full_o),
        .empty_o (credits_empty_o),
        .err_o   (credit_err_o)
    );

    assign dep_status_o = slot_r;
    assign long_busy_o  = long_busy_r;

endmodule
